// File: rtl/cordic_rotator_if.sv
// Request/response bundle for cordic_rotator.
//   theta_i   : signed angle request, 2QN radians (pi = 25736)
//   valid_in  : request strobe, sampled only while busy = 0
//   busy      : high while a request is being rotated
//   cos_o     : signed cos(theta_i), 1QN (1.0 = 16384), held until next result
//   sin_o     : signed sin(theta_i), 1QN, held until next result
//   range_err : qualified by valid_out, |theta_i| > pi
//   valid_out : one-cycle pulse, results valid
interface cordic_rotator_if #(
  parameter int unsigned XY_BITS    = 16,
  parameter int unsigned THETA_BITS = 16
);
  logic signed [THETA_BITS:0] theta_i;
  logic                       valid_in;
  logic                       busy;
  logic signed [XY_BITS:0]    cos_o;
  logic signed [XY_BITS:0]    sin_o;
  logic                       range_err;
  logic                       valid_out;

  // Requester side
  modport master (
    output theta_i, valid_in,
    input  busy, cos_o, sin_o, range_err, valid_out
  );

  // Rotator side
  modport slave (
    input  theta_i, valid_in,
    output busy, cos_o, sin_o, range_err, valid_out
  );
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: angle in, (cos, sin) out, one micro-rotation per clock,
// single request in flight.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : cordic_rotator_if.slave (theta_i/valid_in in; busy/cos_o/sin_o/range_err/valid_out out)
module cordic_rotator #(
  parameter int unsigned XY_BITS    = 16,
  parameter int unsigned THETA_BITS = 16,
  parameter int unsigned ITERATIONS = 14
) (
  input  logic            clk,
  input  logic            rst,
  cordic_rotator_if.slave bus
);

  localparam int unsigned XW = XY_BITS + 3;     // internal x/y width, 2 headroom bits
  localparam int unsigned ZW = THETA_BITS + 2;  // internal angle width
  localparam int unsigned OW = XY_BITS + 1;     // output width
  localparam int unsigned TW = THETA_BITS + 1;  // input angle width
  localparam int unsigned CW = 5;               // iteration counter width

  localparam logic signed [ZW-1:0] PI_Z      = ZW'(25736);
  localparam logic signed [ZW-1:0] HALF_PI_Z = ZW'(12868);
  localparam logic signed [XW-1:0] K_X       = XW'(9949);
  localparam logic signed [XW-1:0] SAT_HI    = XW'((2 ** XY_BITS) - 1);
  localparam logic signed [XW-1:0] SAT_LO    = ~SAT_HI;
  localparam logic [CW-1:0]        LAST_CNT  = CW'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROTATE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic signed [XW-1:0]   x_q, x_d;
  logic signed [XW-1:0]   y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   vout_q, vout_d;
  logic                   rerr_q, rerr_d;
  logic                   oor_q, oor_d;
  logic signed [OW-1:0]   cos_q, cos_d;
  logic signed [OW-1:0]   sin_q, sin_d;

  logic signed [ZW-1:0]   theta_z;
  logic                   theta_oor;
  logic                   theta_far;
  logic signed [XW-1:0]   x_sh;
  logic signed [XW-1:0]   y_sh;
  logic signed [ZW-1:0]   atan_i;

  // atan(2^-i) in 2QN, rounded
  function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] i);
    case (i)
      5'd0:    atan_lut = ZW'(6434);
      5'd1:    atan_lut = ZW'(3798);
      5'd2:    atan_lut = ZW'(2007);
      5'd3:    atan_lut = ZW'(1019);
      5'd4:    atan_lut = ZW'(511);
      5'd5:    atan_lut = ZW'(256);
      5'd6:    atan_lut = ZW'(128);
      5'd7:    atan_lut = ZW'(64);
      5'd8:    atan_lut = ZW'(32);
      5'd9:    atan_lut = ZW'(16);
      5'd10:   atan_lut = ZW'(8);
      5'd11:   atan_lut = ZW'(4);
      5'd12:   atan_lut = ZW'(2);
      5'd13:   atan_lut = ZW'(1);
      5'd14:   atan_lut = ZW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  // Clamp internal x/y into the 1QN output range
  function automatic logic signed [OW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI) begin
      sat = OW'(SAT_HI);
    end else if (v < SAT_LO) begin
      sat = OW'(SAT_LO);
    end else begin
      sat = OW'(v);
    end
  endfunction

  // Request angle decode: sign-extend, range check, quadrant fold
  assign theta_z   = {{(ZW - TW){bus.theta_i[THETA_BITS]}}, bus.theta_i};
  assign theta_oor = (theta_z > PI_Z) || (theta_z < -PI_Z);
  assign theta_far = (theta_z > HALF_PI_Z) || (theta_z < -HALF_PI_Z);

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_lut(cnt_q);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    vout_d  = 1'b0;
    rerr_d  = rerr_q;
    oor_d   = oor_q;
    cos_d   = cos_q;
    sin_d   = sin_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          // Angles beyond +/-pi/2 start from (-K, 0) rotated by theta-+pi
          if (theta_far) begin
            x_d = -K_X;
            z_d = (theta_z[ZW-1]) ? (theta_z + PI_Z) : (theta_z - PI_Z);
          end else begin
            x_d = K_X;
            z_d = theta_z;
          end
          y_d     = '0;
          cnt_d   = '0;
          oor_d   = theta_oor;
          busy_d  = 1'b1;
          state_d = S_ROTATE;
        end
      end

      S_ROTATE: begin
        // Drive residual angle toward zero
        if (!z_q[ZW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (oor_q) begin
          cos_d  = '0;
          sin_d  = '0;
          rerr_d = 1'b1;
        end else begin
          cos_d  = sat(x_q);
          sin_d  = sat(y_q);
          rerr_d = 1'b0;
        end
        vout_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      vout_q  <= 1'b0;
      rerr_q  <= 1'b0;
      oor_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      vout_q  <= vout_d;
      rerr_q  <= rerr_d;
      oor_q   <= oor_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid_out = vout_q;
  assign bus.range_err = rerr_q;
  assign bus.cos_o     = cos_q;
  assign bus.sin_o     = sin_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed vector table, multi-cycle corner
// sequences, and random angles against a real-arithmetic cos/sin model.
module tb_cordic_rotator;

  localparam int LAT      = 15;  // edges from accept edge to valid_out visible
  localparam int DIR_TOL  = 4;
  localparam int RAND_TOL = 6;   // allows for accumulated table/truncation error
  localparam int N_RAND   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_rotator_if #(.XY_BITS(16), .THETA_BITS(16)) bus ();

  cordic_rotator #(
    .XY_BITS(16),
    .THETA_BITS(16),
    .ITERATIONS(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int theta;
    int cos_e;
    int sin_e;
    int err_e;
    int tol;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_tests++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Ideal rotator: true cos/sin of the angle, zeros with error flag when |theta| > pi
  function automatic void ref_model(input int th, output int c, output int s, output int e);
    real a;
    if (th > 25736 || th < -25736) begin
      c = 0; s = 0; e = 1;
    end else begin
      a = real'(th) / 8192.0;
      c = int'($cos(a) * 16384.0);
      s = int'($sin(a) * 16384.0);
      e = 0;
    end
  endfunction

  // Issue one request from idle and wait (bounded) for its result
  task automatic do_req(input int theta, output int c, output int s, output int e,
                        output int lat);
    @(negedge clk);
    bus.theta_i  = 17'(theta);
    bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1, 0);
    lat = 0;
    while (!bus.valid_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    c = int'(bus.cos_o);
    s = int'(bus.sin_o);
    e = int'(bus.range_err);
    chk("busy_at_valid_out", int'(bus.busy), 0, 0);
  endtask

  initial begin
    vec_t vecs[9];
    int c, s, e, lat;
    int ec, es, ee;
    int th;
    int acc, outs;
    int q[$];
    int vcyc[$];

    vecs[0] = '{0,       16384,      0, 0, DIR_TOL};
    vecs[1] = '{12868,       0,  16384, 0, DIR_TOL};
    vecs[2] = '{-8578,    8192, -14189, 0, DIR_TOL};
    vecs[3] = '{25736,  -16384,      0, 0, DIR_TOL};
    vecs[4] = '{-25736, -16384,      0, 0, DIR_TOL};
    vecs[5] = '{26000,       0,      0, 1, 0};
    vecs[6] = '{6434,    11585,  11585, 0, DIR_TOL};
    vecs[7] = '{-30000,      0,      0, 1, 0};
    vecs[8] = '{-12868,      0, -16384, 0, DIR_TOL};

    bus.theta_i  = '0;
    bus.valid_in = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",      int'(bus.busy),      0, 0);
    chk("rst_valid_out", int'(bus.valid_out), 0, 0);
    chk("rst_range_err", int'(bus.range_err), 0, 0);
    chk("rst_cos",       int'(bus.cos_o),     0, 0);
    chk("rst_sin",       int'(bus.sin_o),     0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].theta, c, s, e, lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT, 0);
      chk($sformatf("vec%0d_cos", i), c, vecs[i].cos_e, vecs[i].tol);
      chk($sformatf("vec%0d_sin", i), s, vecs[i].sin_e, vecs[i].tol);
      chk($sformatf("vec%0d_range_err", i), e, vecs[i].err_e, 0);
    end

    // valid_out is a single-cycle pulse
    @(negedge clk);
    chk("valid_out_one_cycle", int'(bus.valid_out), 0, 0);

    // valid_in held high with changing theta: accepts only while idle
    acc = 0;
    outs = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        outs++;
        vcyc.push_back(k);
        if (q.size() == 0) begin
          chk("hold_spurious_valid_out", 1, 0, 0);
        end else begin
          th = q.pop_front();
          ref_model(th, ec, es, ee);
          chk("hold_cos", int'(bus.cos_o), ec, RAND_TOL);
          chk("hold_sin", int'(bus.sin_o), es, RAND_TOL);
        end
      end
      th = int'($urandom_range(51472, 0)) - 25736;
      if (k < 40) begin
        if (!bus.busy) begin
          q.push_back(th);
          acc++;
        end
        bus.theta_i  = 17'(th);
        bus.valid_in = 1'b1;
      end else begin
        bus.valid_in = 1'b0;
      end
    end
    chk("hold_accepts", acc, 3, 0);
    chk("hold_outputs", outs, acc, 0);
    for (int i = 1; i < vcyc.size(); i++) begin
      chk($sformatf("hold_period%0d", i), vcyc[i] - vcyc[i-1], 16, 0);
    end

    // Reset in the middle of a rotation abandons the request
    @(negedge clk);
    bus.theta_i  = 17'(-8578);
    bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy",      int'(bus.busy),      0, 0);
    chk("midrst_valid_out", int'(bus.valid_out), 0, 0);
    chk("midrst_cos",       int'(bus.cos_o),     0, 0);
    chk("midrst_sin",       int'(bus.sin_o),     0, 0);
    @(negedge clk);
    rst = 1'b0;
    outs = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.valid_out) outs++;
    end
    chk("midrst_no_valid_out", outs, 0, 0);
    do_req(4289, c, s, e, lat);
    ref_model(4289, ec, es, ee);
    chk("postrst_latency", lat, LAT, 0);
    chk("postrst_cos", c, ec, DIR_TOL);
    chk("postrst_sin", s, es, DIR_TOL);
    chk("postrst_range_err", e, 0, 0);

    // Random angles, mostly legal, some anywhere in the input range
    for (int i = 0; i < N_RAND; i++) begin
      if (i % 8 == 7) th = int'($urandom_range(131071, 0)) - 65536;
      else            th = int'($urandom_range(51472, 0)) - 25736;
      ref_model(th, ec, es, ee);
      do_req(th, c, s, e, lat);
      chk($sformatf("rand%0d_latency(th=%0d)", i, th), lat, LAT, 0);
      chk($sformatf("rand%0d_cos(th=%0d)", i, th), c, ec, (ee != 0) ? 0 : RAND_TOL);
      chk($sformatf("rand%0d_sin(th=%0d)", i, th), s, es, (ee != 0) ? 0 : RAND_TOL);
      chk($sformatf("rand%0d_range_err(th=%0d)", i, th), e, ee, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
